// File: rtl/control_pkg.sv
// Shared opcodes, sequencer states and instruction classes for the hardwired control unit.
package control_pkg;

   // 5-bit opcodes taken from IR[31:27]
   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHRA = 5'b01000;
   localparam logic [4:0] OP_SHL  = 5'b01001;
   localparam logic [4:0] OP_ROR  = 5'b01010;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_BR   = 5'b10011;
   localparam logic [4:0] OP_JR   = 5'b10100;
   localparam logic [4:0] OP_JAL  = 5'b10101;
   localparam logic [4:0] OP_IN   = 5'b10110;
   localparam logic [4:0] OP_OUT  = 5'b10111;
   localparam logic [4:0] OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   // ALU function used by fetch (PC increment) and by idle states
   localparam logic [4:0] ALU_ADD = OP_ADD;

   // T3..T7 must stay consecutive: execute advances by incrementing the state code
   typedef enum logic [3:0] {
      S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_t;

   typedef enum logic [3:0] {
      CL_ALU_R, CL_ALU_I, CL_UNARY, CL_MULDIV, CL_LD, CL_LDI, CL_ST, CL_BR,
      CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
   } op_class_t;

   // Final execute step of each class; the step after it is always T0
   function automatic state_t last_step(input op_class_t c);
      case (c)
         CL_UNARY, CL_JAL:               last_step = S_T4;
         CL_ALU_R, CL_ALU_I, CL_LDI:     last_step = S_T5;
         CL_MULDIV, CL_BR:               last_step = S_T6;
         CL_LD, CL_ST:                   last_step = S_T7;
         default:                        last_step = S_T3;
      endcase
   endfunction

endpackage

// File: rtl/control_sequencer_op_class_decode.sv
// Maps a 5-bit opcode onto the instruction class that selects the execute sequence.
module op_class_decode
   import control_pkg::*;
(
   input  logic [4:0] op_i,
   output op_class_t  class_o
);

   // Pure lookup; unassigned opcodes fall through to NOP
   always_comb begin
      case (op_i)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
         OP_SHRA, OP_SHL, OP_ROR, OP_ROL:        class_o = CL_ALU_R;
         OP_ADDI, OP_ANDI, OP_ORI:               class_o = CL_ALU_I;
         OP_NEG, OP_NOT:                         class_o = CL_UNARY;
         OP_MUL, OP_DIV:                         class_o = CL_MULDIV;
         OP_LD:                                  class_o = CL_LD;
         OP_LDI:                                 class_o = CL_LDI;
         OP_ST:                                  class_o = CL_ST;
         OP_BR:                                  class_o = CL_BR;
         OP_JR:                                  class_o = CL_JR;
         OP_JAL:                                 class_o = CL_JAL;
         OP_IN:                                  class_o = CL_IN;
         OP_OUT:                                 class_o = CL_OUT;
         OP_MFHI:                                class_o = CL_MFHI;
         OP_MFLO:                                class_o = CL_MFLO;
         OP_HALT:                                class_o = CL_HALT;
         default:                                class_o = CL_NOP;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2, per-class execute T3-T7, Moore strobe decode.
// The current state is also driven on dbg_state_o for checkers.
module control_sequencer
   import control_pkg::*;
(
   input  logic        Clock,
   input  logic        Reset_n,
   input  logic [31:0] IR,
   input  logic        CON,
   input  logic        Stop,
   output logic        Run,
   output logic        PCin,
   output logic        IRin,
   output logic        MARin,
   output logic        MDRin,
   output logic        Yin,
   output logic        Zin,
   output logic        HIin,
   output logic        LOin,
   output logic        CONin,
   output logic        OUTPORTin,
   output logic        Rin,
   output logic        PCout,
   output logic        MDRout,
   output logic        ZHIout,
   output logic        ZLOout,
   output logic        HIout,
   output logic        LOout,
   output logic        INPORTout,
   output logic        Cout,
   output logic        Rout,
   output logic        BAout,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        IncPC,
   output logic        Read,
   output logic        write,
   output logic [4:0]  AluOp,
   output state_t      dbg_state_o
);

   state_t     state_q, state_d;
   logic [4:0] op_q, op_d;
   op_class_t  ir_cls, op_cls;
   logic       unused_ir;

   // Only the opcode field matters to the sequencer
   assign unused_ir   = ^IR[26:0];
   assign dbg_state_o = state_q;

   // Live IR class decides the T2 exit; latched op_q class drives execute
   op_class_decode u_ir_dec (.op_i(IR[31:27]), .class_o(ir_cls));
   op_class_decode u_op_dec (.op_i(op_q),      .class_o(op_cls));

   // State and latched opcode registers
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= S_RST;
         op_q    <= 5'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   // Next state: Stop and halt/nop are only examined on leaving T2
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      case (state_q)
         S_RST:  state_d = S_T0;
         S_T0:   state_d = S_T1;
         S_T1:   state_d = S_T2;
         S_T2: begin
            op_d = IR[31:27];
            if (Stop || ir_cls == CL_HALT) state_d = S_HALT;
            else if (ir_cls == CL_NOP)     state_d = S_T0;
            else                           state_d = S_T3;
         end
         S_T3, S_T4, S_T5, S_T6, S_T7:
            state_d = (state_q == last_step(op_cls)) ? S_T0 : state_t'(state_q + 4'd1);
         S_HALT: state_d = S_HALT;
         default: state_d = S_RST;
      endcase
   end

   // Moore strobe decode on (state, class); only br T6 also looks at CON
   always_comb begin
      {PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, OUTPORTin, Rin,
       PCout, MDRout, ZHIout, ZLOout, HIout, LOout, INPORTout, Cout, Rout, BAout,
       Gra, Grb, Grc, IncPC, Read, write} = 27'd0;
      AluOp = ALU_ADD;
      Run   = (state_q != S_RST) && (state_q != S_HALT);
      case (state_q)
         S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
         S_T1: begin Read = 1'b1; MDRin = 1'b1; PCin = 1'b1; end
         S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
         S_T3: case (op_cls)
            CL_ALU_R, CL_ALU_I:   begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            CL_UNARY:             begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; AluOp = op_q; end
            CL_MULDIV:            begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            CL_LD, CL_LDI, CL_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
            CL_BR:                begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
            CL_JR:                begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            CL_JAL:               begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
            CL_IN:                begin INPORTout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            CL_OUT:               begin Gra = 1'b1; Rout = 1'b1; OUTPORTin = 1'b1; end
            CL_MFHI:              begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            CL_MFLO:              begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            default: ;
         endcase
         S_T4: case (op_cls)
            CL_ALU_R:             begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; AluOp = op_q; end
            CL_ALU_I, CL_LD, CL_LDI, CL_ST:
                                  begin Cout = 1'b1; Zin = 1'b1; AluOp = op_q; end
            CL_UNARY:             begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            CL_MULDIV:            begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; AluOp = op_q; end
            CL_BR:                begin PCout = 1'b1; Yin = 1'b1; end
            CL_JAL:               begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            default: ;
         endcase
         S_T5: case (op_cls)
            CL_ALU_R, CL_ALU_I, CL_LDI:
                                  begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            CL_MULDIV:            begin ZLOout = 1'b1; LOin = 1'b1; end
            CL_LD, CL_ST:         begin ZLOout = 1'b1; MARin = 1'b1; end
            CL_BR:                begin Cout = 1'b1; Zin = 1'b1; AluOp = op_q; end
            default: ;
         endcase
         S_T6: case (op_cls)
            CL_MULDIV:            begin ZHIout = 1'b1; HIin = 1'b1; end
            CL_LD:                begin Read = 1'b1; MDRin = 1'b1; end
            CL_ST:                begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
            CL_BR:                begin ZLOout = 1'b1; PCin = CON; end
            default: ;
         endcase
         S_T7: case (op_cls)
            CL_LD:                begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            CL_ST:                write = 1'b1;
            default: ;
         endcase
         default: ;
      endcase
   end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the 32-bit single-bus datapath. Steps through fetch (T0–T2) and per-opcode execute steps (T3–T7), driving every register-enable, bus-select and memory strobe the datapath takes. Decodes the instruction register and uses the CON flip-flop result for conditional branches. Sits directly upstream of `datapath`, replacing the hand-driven strobes used in stage testbenches.

## Interface
- No parameters; opcodes and states come from `control_pkg`.
- `Clock`  in  1  system clock; all state changes on rising edge
- `Reset_n`  in  1  asynchronous, active-low reset
- `IR`  in  32  instruction register; opcode = `IR[31:27]`
- `CON`  in  1  CON flip-flop output
- `Stop`  in  1  halt request, sampled only at the T2→T3 boundary
- `Run`  out  1  high while sequencing; low in RST and HALT
- Register enables (each out, 1): `PCin`, `IRin`, `MARin`, `MDRin`, `Yin`, `Zin`, `HIin`, `LOin`, `CONin`, `OUTPORTin`, `Rin`
- Bus drivers (each out, 1): `PCout`, `MDRout`, `ZHIout`, `ZLOout`, `HIout`, `LOout`, `INPORTout`, `Cout`, `Rout`, `BAout`
- Select/strobe (each out, 1): `Gra`, `Grb`, `Grc`, `IncPC`, `Read`, `write`
- `AluOp`  out  5  ALU function; equals opcode during execute Zin steps, ADD (00011) otherwise

## Operation
- States: RST, T0–T7, HALT. Moore outputs: combinational decode of state and latched opcode. One step per clock.
- Fetch: T0 `PCout MARin IncPC Zin`; T1 `Read MDRin PCin`; T2 `MDRout IRin`.
- At end of T2, the opcode is latched from `IR` into `op_q`. Execute decodes `op_q`, never live `IR`.
- ALU reg-reg (add, sub, and, or, shr, shra, shl, ror, rol): T3 `Grb Rout Yin`; T4 `Grc Rout Zin`; T5 `ZLOout Gra Rin`.
- addi/andi/ori: T3 `Grb Rout Yin`; T4 `Cout Zin`; T5 `ZLOout Gra Rin`.
- neg/not: T3 `Grb Rout Zin`; T4 `ZLOout Gra Rin`.
- mul/div: T3 `Gra Rout Yin`; T4 `Grb Rout Zin`; T5 `ZLOout LOin`; T6 `ZHIout HIin`.
- ld: T3 `Grb BAout Yin`; T4 `Cout Zin`; T5 `ZLOout MARin`; T6 `Read MDRin`; T7 `MDRout Gra Rin`.
- ldi: same as ld through T4; T5 `ZLOout Gra Rin`.
- st: same as ld through T5; T6 `Gra Rout MDRin`; T7 `write`.
- br: T3 `Gra Rout CONin`; T4 `PCout Yin`; T5 `Cout Zin`; T6 `ZLOout`, plus `PCin` only if `CON`=1.
- jr: T3 `Gra Rout PCin`.
- jal: T3 `PCout Grb Rin` (Rb field = link register); T4 `Gra Rout PCin`.
- in: T3 `INPORTout Gra Rin`. out: T3 `Gra Rout OUTPORTin`. mfhi/mflo: T3 `HIout`/`LOout` `Gra Rin`.
- nop: T2→T0. halt: T2→HALT. Undefined opcodes are treated as nop.
- After the last execute step of any instruction, the next state is T0.

## Timing
- Reset (async, `Reset_n`=0): state RST, `op_q`=0, every output 0 except `AluOp`=00011, `Run`=0.
- First rising edge with `Reset_n`=1: RST→T0, `Run`=1.
- Instruction length: 3 cycles (nop), 4 (in/out/mfhi/mflo/jr), 5 (neg/not/jal), 6 (ALU, ldi), 7 (mul/div, br), 8 (ld/st).
- `CON` is sampled combinationally in br T6. CONin in T3 sets the flip-flop at the T3→T4 edge, so `CON` is stable by T6.
- `Stop`=1 at the T2→T3 edge: go to HALT and discard the fetched instruction. `Stop` is ignored in all other states.
- HALT holds all outputs 0 until `Reset_n` is asserted. A reset mid-instruction aborts the instruction immediately.
- `write` and `Read` are never asserted in the same cycle.

## Structure
- `control_pkg`: opcode localparams (5-bit, ld=00000 … halt=11011), state enum, ADD constant.
- Sub-module `op_class_decode`: maps opcode to an instruction-class enum (ALU_R, ALU_I, UNARY, MULDIV, LD, LDI, ST, BR, JR, JAL, IN, OUT, MFHI, MFLO, NOP, HALT).
- Top module: state register, `op_q` register, and an output decode keyed on (state, class).

## Test plan
- Reset release, IR=add R1,R2,R3 → T0..T5 then T0. T4 has `Grc Rout Zin` with `AluOp`=00011; T5 has `ZLOout Gra Rin`.
- br (brnz) with `CON`=1 and again with `CON`=0 → `PCin` high in T6 only when `CON`=1; both return to T0 after 7 cycles.
- st → T7 asserts `write` only; `Read` stays 0 in T6/T7; next T0 follows.
- `Stop`=1 at the T2 edge, and separately IR=halt → HALT, `Run`=0, outputs held 0 for 10 cycles.
- `Reset_n` pulsed low during ld T5 → outputs 0 asynchronously; on release, RST→T0.
- Undefined opcode 11111 → T0,T1,T2,T0 with no execute strobes.
